// File: rtl/masked_chi_toffoli_iter_if.sv
// rtl/masked_chi_toffoli_iter_if.sv - row-in / row-out handshake bundle for the masked chi block
interface masked_chi_toffoli_iter_if #(
    parameter int N = 5
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] share0_in;
    logic [N-1:0] share1_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] share0_out;
    logic [N-1:0] share1_out;

    modport master (
        output in_valid, share0_in, share1_in, out_ready,
        input  in_ready, out_valid, share0_out, share1_out
    );

    modport slave (
        input  in_valid, share0_in, share1_in, out_ready,
        output in_ready, out_valid, share0_out, share1_out
    );
endinterface

// File: rtl/masked_chi_toffoli_iter.sv
// rtl/masked_chi_toffoli_iter.sv - iterative 2-share masked chi, one Toffoli step per two cycles
module masked_chi_toffoli_iter #(
    parameter int N     = 5,
    parameter int CNT_W = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    masked_chi_toffoli_iter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PH_A, PH_B, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] PENULT = CNT_W'(N - 2);

    state_t           state;
    logic [CNT_W-1:0] step;
    logic [N-1:0]     r0;
    logic [N-1:0]     r1;
    // Saved x_0 / x_1, index [0] = share 0, [1] = share 1; the row copies get
    // overwritten with y_0 / y_1 before the last two steps need them.
    logic [1:0]       sav_x0;
    logic [1:0]       sav_x1;
    logic             p0;
    logic             p1;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [N-1:0]     out0_q;
    logic [N-1:0]     out1_q;

    logic a0, a1, b0, b1, c0, c1;
    logic y0, y1;

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.share0_out = out0_q;
    assign bus.share1_out = out1_q;

    // Operand select: the last two steps wrap around onto the saved x_0 / x_1
    always_comb begin
        a0 = r0[0];
        a1 = r1[0];
        b0 = r0[1];
        b1 = r1[1];
        c0 = r0[2];
        c1 = r1[2];
        if (step == LAST) begin
            b0 = sav_x0[0];
            b1 = sav_x0[1];
            c0 = sav_x1[0];
            c1 = sav_x1[1];
        end else if (step == PENULT) begin
            c0 = sav_x0[0];
            c1 = sav_x0[1];
        end
    end

    // Second half of the Toffoli: only share 0 of c meets the registered partials
    always_comb begin
        y0 = p0 ^ (c0 & ~b0);
        y1 = p1 ^ (c0 & b1);
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step        <= '0;
            r0          <= '0;
            r1          <= '0;
            sav_x0      <= '0;
            sav_x1      <= '0;
            p0          <= 1'b0;
            p1          <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        r0         <= bus.share0_in;
                        r1         <= bus.share1_in;
                        sav_x0     <= {bus.share1_in[0], bus.share0_in[0]};
                        sav_x1     <= {bus.share1_in[1], bus.share0_in[1]};
                        step       <= '0;
                        in_ready_q <= 1'b0;
                        state      <= PH_A;
                    end
                end
                PH_A: begin
                    // Share 1 of c only; registered before share 0 is folded in
                    p0    <= a0 ^ (c1 & ~b0);
                    p1    <= a1 ^ (c1 & b1);
                    state <= PH_B;
                end
                PH_B: begin
                    r0 <= {y0, r0[N-1:1]};
                    r1 <= {y1, r1[N-1:1]};
                    if (step == LAST) begin
                        step        <= '0;
                        out0_q      <= {y0, r0[N-1:1]};
                        out1_q      <= {y1, r1[N-1:1]};
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        step  <= step + 1'b1;
                        state <= PH_A;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_masked_chi_toffoli_iter.sv
// tb/tb_masked_chi_toffoli_iter.sv - randomized self-checking bench for masked_chi_toffoli_iter
module tb_masked_chi_toffoli_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    masked_chi_toffoli_iter_if #(.N(5)) ifa ();
    masked_chi_toffoli_iter_if #(.N(3)) ifb ();

    masked_chi_toffoli_iter #(.N(5)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    masked_chi_toffoli_iter #(.N(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Unmasked chi straight from the row equation
    function automatic logic [4:0] chi_ref(input logic [4:0] x, input int n);
        logic [4:0] y;
        y = '0;
        for (int i = 0; i < n; i++)
            y[i] = x[i] ^ (~x[(i + 1) % n] & x[(i + 2) % n]);
        return y;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input int n, input logic v, input logic [4:0] s0, input logic [4:0] s1);
        if (n == 5) begin
            ifa.in_valid = v; ifa.share0_in = s0; ifa.share1_in = s1;
        end else begin
            ifb.in_valid = v; ifb.share0_in = s0[2:0]; ifb.share1_in = s1[2:0];
        end
    endtask

    function automatic logic rdy(input int n);
        return (n == 5) ? ifa.in_ready : ifb.in_ready;
    endfunction

    function automatic logic ovld(input int n);
        return (n == 5) ? ifa.out_valid : ifb.out_valid;
    endfunction

    function automatic logic [4:0] outx(input int n);
        return (n == 5) ? (ifa.share0_out ^ ifa.share1_out)
                        : {2'b00, ifb.share0_out ^ ifb.share1_out};
    endfunction

    task automatic accept(input int n, input logic [4:0] s0, input logic [4:0] s1);
        int w;
        w = 0;
        drive_in(n, 1'b1, s0, s1);
        while (!rdy(n) && w < 50) begin tick; w++; end
        if (w >= 50) check("accept_timeout", 32'd0, 32'd1);
        tick;
        drive_in(n, 1'b0, '0, '0);
    endtask

    task automatic wait_out(input int n, output int lat);
        lat = 0;
        while (!ovld(n) && lat < 100) begin tick; lat++; end
        if (lat >= 100) check("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_row(input int n, input logic [4:0] x, input logic [4:0] s0,
                           input string tag, input logic chk_lat);
        logic [4:0] msk;
        logic [4:0] m0;
        int lat;
        msk = 5'((1 << n) - 1);
        m0  = s0 & msk;
        accept(n, m0, (x ^ m0) & msk);
        wait_out(n, lat);
        if (chk_lat) check({tag, "_lat"}, 32'(lat), 32'(2 * n));
        check(tag, 32'(outx(n)), 32'(chi_ref(x & msk, n)));
        tick;
    endtask

    initial begin
        logic [4:0] held0, held1, x;
        int lat;
        rst = 1'b1;
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        drive_in(5, 1'b0, '0, '0);
        drive_in(3, 1'b0, '0, '0);
        #22;
        check("rst_in_ready", 32'(ifa.in_ready), 32'd0);
        check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_out", 32'({ifa.share0_out, ifa.share1_out}), 32'd0);
        #10 rst = 1'b0;
        #1;
        check("rel_in_ready_pre", 32'(ifa.in_ready), 32'd0);
        tick;
        check("rel_in_ready", 32'(ifa.in_ready), 32'd1);

        // Directed vector with explicit shares
        accept(5, 5'b10110, 5'b10111);
        wait_out(5, lat);
        check("dir_lat", 32'(lat), 32'd10);
        check("dir_x00001", 32'(outx(5)), 32'h09);
        tick;

        run_row(5, 5'b00010, 5'($urandom), "x00010", 1'b1);
        check("x00010_const", 32'(chi_ref(5'b00010, 5)), 32'h12);
        run_row(5, 5'b11111, 5'($urandom), "x11111", 1'b1);
        run_row(5, 5'b00000, 5'($urandom), "x00000", 1'b1);

        // Exhaustive x, random maskings, both widths
        for (int v = 0; v < 32; v++)
            for (int m = 0; m < 8; m++)
                run_row(5, 5'(v), 5'($urandom), "exh5", (m == 0));
        for (int v = 0; v < 8; v++)
            for (int m = 0; m < 8; m++)
                run_row(3, 5'(v), 5'($urandom), "exh3", (m == 0));

        // Backpressure
        ifa.out_ready = 1'b0;
        accept(5, 5'b01101, 5'b11000);
        wait_out(5, lat);
        check("bp_lat", 32'(lat), 32'd10);
        held0 = ifa.share0_out;
        held1 = ifa.share1_out;
        check("bp_val", 32'(held0 ^ held1), 32'(chi_ref(5'b10101, 5)));
        for (int k = 0; k < 7; k++) begin
            tick;
            check("bp_valid", 32'(ifa.out_valid), 32'd1);
            check("bp_hold", 32'({ifa.share0_out, ifa.share1_out}), 32'({held0, held1}));
            check("bp_in_ready", 32'(ifa.in_ready), 32'd0);
        end
        ifa.out_ready = 1'b1;
        tick;
        ifa.out_ready = 1'b0;
        check("bp_release_ready", 32'(ifa.in_ready), 32'd1);
        check("bp_release_valid", 32'(ifa.out_valid), 32'd0);
        ifa.out_ready = 1'b1;

        // Asynchronous reset in PH_B of step 2 (outputs still hold the previous row)
        accept(5, 5'b00111, 5'b11010);
        for (int k = 0; k < 5; k++) tick;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(ifa.out_valid), 32'd0);
        check("arst_out", 32'({ifa.share0_out, ifa.share1_out}), 32'd0);
        check("arst_in_ready", 32'(ifa.in_ready), 32'd0);
        #2 rst = 1'b0;
        run_row(5, 5'b10011, 5'($urandom), "post_rst", 1'b1);

        // in_valid pulses mid-computation must be ignored
        x = 5'b01011;
        accept(5, 5'b11100, x ^ 5'b11100);
        for (int k = 0; k < 6; k++) begin
            drive_in(5, 1'b1, 5'($urandom), 5'($urandom));
            tick;
        end
        drive_in(5, 1'b0, '0, '0);
        wait_out(5, lat);
        check("ign_lat", 32'(lat + 6), 32'd10);
        check("ign_val", 32'(outx(5)), 32'(chi_ref(x, 5)));
        tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/masked_chi_toffoli_iter.md
Name: masked_chi_toffoli_iter

Overview:
- Iterative, 2-share, first-order masked Keccak-style chi on an N-bit row: y_i = x_i ^ (~x_{i+1} & x_{i+2}), indices mod N.
- Computes one bit per Toffoli step. Each step is split over two register stages, so share 1 and share 0 of the c operand are never combined in the same stage.
- Generalises the fixed 3-bit unrolled masked chi to any odd row width N, adds valid/ready handshakes, and saves the wrap-around operands so it is correct for N>3 (e.g. chi5 for Keccak-f).
- Sits between state-row buffering and the next masked round stage.

Parameters:
- N, 5, row width in bits; odd, N>=3.
- CNT_W, $clog2(N), width of the step counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input row valid.
- in_ready  out  1  block idle and able to accept a row.
- share0_in  in  N  input share 0; bit i is x_i share 0.
- share1_in  in  N  input share 1.
- out_valid  out  1  result row valid.
- out_ready  in  1  consumer accepts the result.
- share0_out  out  N  result share 0.
- share1_out  out  N  result share 1.

Behaviour:
- Reset (asynchronous assert, synchronous release), all registers cleared:
  - in_ready=0 during reset, 1 in the first cycle after release.
  - out_valid=0; share0_out=0; share1_out=0; step counter=0.
  - FSM = IDLE.
  - A reset mid-computation discards the row; no partial output.
- FSM states: IDLE, PH_A, PH_B, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load r0<=share0_in, r1<=share1_in.
  - Save copies of x_0 and x_1 (both shares, 4 bits): s0 = x_0 shares, s1 = x_1 shares.
  - step<=0; go to PH_A.
- Register invariant at step i: r*[k] holds x_{(i+k) mod N}. Bits with index < i already hold y values.
- Operand selection at step i:
  - a = r[0].
  - b = r[1], except i=N-1 uses s0.
  - c = r[2], except i=N-2 uses s0 and i=N-1 uses s1.
- PH_A (uses share 1 of c only):
  - p0 <= a0 ^ (c1 & ~b0).
  - p1 <= a1 ^ (c1 & b1).
  - Go to PH_B.
- PH_B (uses share 0 of c only):
  - y0 = p0 ^ (c0 & ~b0); y1 = p1 ^ (c0 & b1).
  - Rotate both share registers right by one, writing y into the vacated MSB: r <= {y, r[N-1:1]}.
  - If step==N-1, go to DONE with step<=0; else step<=step+1 and go to PH_A.
- Non-completeness: within a stage, no single gate combines c0 and c1. p0/p1 are registered before the c0 terms are added.
- DONE:
  - out_valid=1; share0_out/share1_out = r0/r1, driven from registers (no combinational path from inputs).
  - Outputs held stable while out_valid & !out_ready.
  - On out_ready: go to IDLE; in_ready=1 in the following cycle.
- Latency: out_valid rises exactly 2N clocks after the accepting edge (N=5: 10 cycles).
- Throughput: one row per 2N+2 cycles with out_ready tied high.
- in_valid is ignored outside IDLE. share*_in need only be stable on the accepting edge.
- Unmasked value = share0 ^ share1. Only the XOR of the output shares is specified, not the individual share values.

Test Plan:
- N=5, share0_in=5'b10110, share1_in=5'b10111 (x=5'b00001), out_ready=1 -> out_valid exactly 10 cycles after accept; share0_out^share1_out=5'b01001.
- N=5, x=5'b00010 with random share0 -> XOR of output shares = 5'b10010. x=5'b11111 -> 5'b11111. x=0 -> 0.
- N=5, exhaustive over 32 x values × 8 random maskings each, compared against an unmasked chi model -> all match. Repeat the exhaustive run with N=3.
- Backpressure: out_ready=0 for 7 cycles after out_valid -> outputs and out_valid stable, in_ready=0. Then out_ready=1 for one cycle -> in_ready=1 next cycle.
- Reset asserted asynchronously mid-PH_B at step 2 -> out_valid=0 and outputs=0 immediately. After release, a new row completes correctly in 10 cycles.
- in_valid pulsed during PH_A/PH_B with different data -> ignored; the result still matches the first accepted row.
